// File: rtl/audio_codec_pkg.sv
// Shared audio codec types and frame constants for the DAC serializer path.
package audio_codec_pkg;

    localparam int unsigned SAMPLE_W          = 16;
    localparam int unsigned SLOTS_PER_CHANNEL = 16;
    localparam int unsigned SLOTS_PER_FRAME   = 32;
    localparam int unsigned SLOT_W            = $clog2(SLOTS_PER_FRAME);

    typedef logic signed [SAMPLE_W-1:0] Sample;
    typedef logic [SLOT_W-1:0]          slot_t;

    localparam slot_t SLOT_LEFT_START  = slot_t'(0);
    localparam slot_t SLOT_RIGHT_START = slot_t'(SLOTS_PER_CHANNEL);

    function automatic Sample attenuate(input Sample s, input logic [2:0] vol);
        return s >>> vol;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO; DEPTH must be a power of two so pointers wrap naturally.
module sample_fifo
    import audio_codec_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  Sample            push_data_i,
    input  logic             pop_i,
    output Sample            pop_data_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);

    Sample            mem_q [DEPTH];
    Sample            mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full_o     = (level_q == LVL_W'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/codec_dac_serializer.sv
// Left-justified mono-to-stereo DAC serializer with BCLK/LRCK generation and sample FIFO.
// Define AUDIO_VOLUME_EN to add the VOLUME attenuation port.
module codec_dac_serializer
    import audio_codec_pkg::*;
#(
    parameter int unsigned BCLK_HALF = 16,
    parameter int unsigned DEPTH     = 4,
    localparam int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  Sample            SAMPLE,
    input  logic             SAMPLE_VALID,
    output logic             SAMPLE_READY,
    input  logic             CLEAR_FLAGS,
`ifdef AUDIO_VOLUME_EN
    input  logic [2:0]       VOLUME,
`endif
    output logic             AUD_BCLK,
    output logic             AUD_DACLRCK,
    output logic             AUD_DACDAT,
    output logic [LVL_W-1:0] FIFO_LEVEL,
    output logic             UNDERRUN,
    output logic             OVERRUN
);

    localparam int unsigned DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    slot_t            slot_q, slot_d;
    Sample            held_q, held_d;
    Sample            shreg_q, shreg_d;
    logic             underrun_q, underrun_d;
    logic             overrun_q, overrun_d;

    logic             tc, fall, frame_start;
    slot_t            slot_next;
    logic             fifo_full, fifo_empty, fifo_pop;
    Sample            fifo_head, load_src, load_word;

    assign tc          = (div_q == DIV_MAX);
    assign fall        = tc && bclk_q;
    assign slot_next   = slot_q + 1'b1;
    assign frame_start = fall && (slot_next == SLOT_LEFT_START);
    // An empty FIFO at frame start takes the underrun path even if a push lands this cycle.
    assign fifo_pop    = frame_start && !fifo_empty;
    assign load_src    = fifo_pop ? fifo_head : held_q;

`ifdef AUDIO_VOLUME_EN
    assign load_word = attenuate(load_src, VOLUME);
`else
    assign load_word = load_src;
`endif

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .push_i      (SAMPLE_VALID),
        .push_data_i (SAMPLE),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .level_o     (FIFO_LEVEL),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        div_d      = tc ? '0 : div_q + 1'b1;
        bclk_d     = tc ? ~bclk_q : bclk_q;
        slot_d     = slot_q;
        held_d     = held_q;
        shreg_d    = shreg_q;
        underrun_d = underrun_q;
        overrun_d  = overrun_q;

        if (CLEAR_FLAGS) begin
            underrun_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (SAMPLE_VALID && fifo_full) begin
            overrun_d = 1'b1;
        end

        if (fall) begin
            slot_d = slot_next;
            if (slot_next == SLOT_LEFT_START) begin
                held_d  = load_src;
                shreg_d = load_word;
                if (fifo_empty) begin
                    underrun_d = 1'b1;
                end
            end else if (slot_next == SLOT_RIGHT_START) begin
                shreg_d = load_word;
            end else begin
                shreg_d = {shreg_q[SAMPLE_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            slot_q     <= '1;
            held_q     <= '0;
            shreg_q    <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            slot_q     <= slot_d;
            held_q     <= held_d;
            shreg_q    <= shreg_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign SAMPLE_READY = !fifo_full;
    assign AUD_BCLK     = bclk_q;
    assign AUD_DACLRCK  = (slot_q < SLOT_RIGHT_START);
    assign AUD_DACDAT   = shreg_q[SAMPLE_W-1];
    assign UNDERRUN     = underrun_q;
    assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_codec_dac_serializer.sv
// Scoreboard bench for codec_dac_serializer: stimulus queues expected frame words,
// a BCLK-driven monitor reassembles each frame and compares it.
`timescale 1ns/1ps
module tb_codec_dac_serializer;
    import audio_codec_pkg::*;

    localparam int unsigned BCLK_HALF = 2;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1;
    localparam int          FRAME     = 128;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    Sample            SAMPLE = '0;
    logic             SAMPLE_VALID = 1'b0;
    logic             SAMPLE_READY;
    logic             CLEAR_FLAGS = 1'b0;
`ifdef AUDIO_VOLUME_EN
    logic [2:0]       VOLUME = 3'd0;
`endif
    logic             AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;
    logic [LVL_W-1:0] FIFO_LEVEL;
    logic             UNDERRUN, OVERRUN;

    codec_dac_serializer #(
        .BCLK_HALF (BCLK_HALF),
        .DEPTH     (DEPTH)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .SAMPLE       (SAMPLE),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_READY (SAMPLE_READY),
        .CLEAR_FLAGS  (CLEAR_FLAGS),
`ifdef AUDIO_VOLUME_EN
        .VOLUME       (VOLUME),
`endif
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_DACDAT   (AUD_DACDAT),
        .FIFO_LEVEL   (FIFO_LEVEL),
        .UNDERRUN     (UNDERRUN),
        .OVERRUN      (OVERRUN)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad = 0;
    int          edge_cnt = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sample DACDAT/LRCK at each BCLK rise, starting a frame on LRCK going high.
    initial begin
        logic [31:0] frame_bits;
        logic [15:0] w;
        int          bit_cnt;
        int          lr_err;
        bit          active;
        logic        prev_b, prev_l;
        active = 0; prev_b = 0; prev_l = 0; bit_cnt = 0; lr_err = 0; frame_bits = '0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                active = 0;
                prev_b = 0;
                prev_l = 0;
            end else begin
                if (AUD_BCLK && !prev_b) begin
                    if (AUD_DACLRCK && !prev_l) begin
                        active = 1;
                        bit_cnt = 0;
                        lr_err = 0;
                    end
                    if (active) begin
                        frame_bits[31-bit_cnt] = AUD_DACDAT;
                        if (AUD_DACLRCK !== (bit_cnt < 16)) lr_err++;
                        bit_cnt++;
                        if (bit_cnt == 32) begin
                            active = 0;
                            check("frame_expected", 32'(exp_q.size() != 0), 1);
                            if (exp_q.size() != 0) begin
                                w = exp_q.pop_front();
                                check("left_word", frame_bits[31:16], w);
                                check("right_word", frame_bits[15:0], w);
                                check("lrck_pattern", lr_err, 0);
                            end
                        end
                    end
                    prev_l = AUD_DACLRCK;
                end
                prev_b = AUD_BCLK;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_cnt++;
    endtask

    task automatic goto_edge(input int e);
        while (edge_cnt < e) tick();
    endtask

    task automatic push_at(input int e, input logic [15:0] v);
        goto_edge(e - 1);
        SAMPLE = v;
        SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0;
    endtask

    task automatic reset_dut();
        RESET = 1'b1;
        SAMPLE_VALID = 1'b0;
        CLEAR_FLAGS = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic finish_test(input string tag, input int frames);
        goto_edge(FRAME * frames + 8);
        check({tag, "_frames_left"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bclk"}, AUD_BCLK, 0);
        check({tag, "_lrck"}, AUD_DACLRCK, 0);
        check({tag, "_dat"}, AUD_DACDAT, 0);
        check({tag, "_level"}, FIFO_LEVEL, 0);
        check({tag, "_underrun"}, UNDERRUN, 0);
        check({tag, "_overrun"}, OVERRUN, 0);
        check({tag, "_ready"}, SAMPLE_READY, 1);
    endtask

    // Idle run from reset: BCLK cadence, first frame start, set-wins-over-clear, then clear.
    task automatic run_basic(input string tag);
        exp_q.push_back(16'h0000);
        check_reset_outputs({tag, "_rst"});
        for (int e = 1; e <= 8; e++) begin
            if (e == 4) CLEAR_FLAGS = 1'b1;
            tick();
            CLEAR_FLAGS = 1'b0;
            check($sformatf("%s_bclk_e%0d", tag, e), AUD_BCLK, (e >> 1) & 1);
            if (e == 3) begin
                check({tag, "_underrun_pre"}, UNDERRUN, 0);
                check({tag, "_lrck_pre"}, AUD_DACLRCK, 0);
            end
            if (e == 4) begin
                check({tag, "_underrun_setwins"}, UNDERRUN, 1);
                check({tag, "_lrck_slot0"}, AUD_DACLRCK, 1);
            end
        end
        goto_edge(9);
        CLEAR_FLAGS = 1'b1;
        tick();
        CLEAR_FLAGS = 1'b0;
        check({tag, "_underrun_clr"}, UNDERRUN, 0);
        finish_test(tag, 1);
    endtask

    initial begin
        logic [15:0] vals [5];
        vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

        // 1: idle after reset
        reset_dut();
        run_basic("t1");

        // 2: single sample, then underrun repeats it
        reset_dut();
        exp_q.push_back(16'h8001);
        exp_q.push_back(16'h8001);
        push_at(1, 16'h8001);
        check("t2_level_push", FIFO_LEVEL, 1);
        goto_edge(4);
        check("t2_level_pop", FIFO_LEVEL, 0);
        check("t2_underrun_f1", UNDERRUN, 0);
        goto_edge(4 + FRAME);
        check("t2_underrun_f2", UNDERRUN, 1);
        finish_test("t2", 2);

        // 3: overfill, drop, clear
        reset_dut();
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 4; i++) exp_q.push_back(vals[i]);
        exp_q.push_back(vals[3]);
        goto_edge(4);
        for (int i = 0; i < 5; i++) begin
            SAMPLE = vals[i];
            SAMPLE_VALID = 1'b1;
            tick();
            if (i == 2) check("t3_ready_l3", SAMPLE_READY, 1);
            if (i == 3) begin
                check("t3_level_full", FIFO_LEVEL, 4);
                check("t3_ready_full", SAMPLE_READY, 0);
                check("t3_overrun_pre", OVERRUN, 0);
            end
            if (i == 4) begin
                check("t3_overrun", OVERRUN, 1);
                check("t3_level_drop", FIFO_LEVEL, 4);
            end
        end
        SAMPLE_VALID = 1'b0;
        CLEAR_FLAGS = 1'b1;
        tick();
        CLEAR_FLAGS = 1'b0;
        check("t3_overrun_clr", OVERRUN, 0);
        goto_edge(4 + FRAME);
        check("t3_level_f2", FIFO_LEVEL, 3);
        check("t3_underrun_f2", UNDERRUN, 0);
        finish_test("t3", 6);

        // 4: push coinciding with pop on empty FIFO
        reset_dut();
        exp_q.push_back(16'hABCD);
        exp_q.push_back(16'hABCD);
        exp_q.push_back(16'h1234);
        push_at(1, 16'hABCD);
        goto_edge(4);
        check("t4_level_f1", FIFO_LEVEL, 0);
        check("t4_underrun_f1", UNDERRUN, 0);
        push_at(4 + FRAME, 16'h1234);
        check("t4_level_same", FIFO_LEVEL, 1);
        check("t4_underrun_same", UNDERRUN, 1);
        finish_test("t4", 3);

        // 5: asynchronous reset in slot 7
        reset_dut();
        push_at(1, 16'h8001);
        goto_edge(4);
        for (int i = 0; i < 5; i++) begin
            SAMPLE = vals[i];
            SAMPLE_VALID = 1'b1;
            tick();
        end
        SAMPLE_VALID = 1'b0;
        goto_edge(34);
        check("t5_lrck_slot7", AUD_DACLRCK, 1);
        check("t5_level_pre", FIFO_LEVEL, 4);
        check("t5_overrun_pre", OVERRUN, 1);
        RESET = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        reset_dut();
        run_basic("t5");

`ifdef AUDIO_VOLUME_EN
        // 6: attenuation by 2
        reset_dut();
        VOLUME = 3'd2;
        exp_q.push_back(16'hE000);
        exp_q.push_back(16'h1000);
        push_at(1, 16'h8000);
        push_at(2, 16'h4000);
        finish_test("t6", 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
